// File: rtl/alu_scheduler_if.sv
// Requester-side port bundle for alu_scheduler: operation request handshake plus
// the per-requester response channel.
interface alu_scheduler_if;
    logic        valid;
    logic        ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_illegal;

    modport master (
        output valid, opcode, funct3, funct7, rs1, rs2, imm,
        input  ready, rsp_valid, rsp_data, rsp_illegal
    );

    modport slave (
        input  valid, opcode, funct3, funct7, rs1, rs2, imm,
        output ready, rsp_valid, rsp_data, rsp_illegal
    );
endinterface

// File: rtl/alu_scheduler.sv
// Two-requester round-robin scheduler for a shared single-cycle-issue ALU: decodes
// RV32I integer ops to a one-hot select, holds operands for SETTLE_CYCLES, returns results.
module alu_scheduler #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic           clk,
    input  logic           reset,
    alu_scheduler_if.slave req0,
    alu_scheduler_if.slave req1,
    output logic [31:0]    alu_rs1,
    output logic [31:0]    alu_rs2,
    output logic [31:0]    alu_imm,
    output logic [36:0]    alu_instr,
    input  logic [31:0]    alu_result
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg;
    logic              last_grant_reg;
    logic              owner_reg;
    logic              illegal_reg;
    logic [36:0]       instr_reg;
    logic [31:0]       rs1_reg, rs2_reg, imm_reg;
    logic [1:0][31:0]  data_reg;

    logic              grant;
    logic              accept;
    logic              legal;
    logic              last_issue;
    logic [6:0]        sel_opcode;
    logic [2:0]        sel_funct3;
    logic [6:0]        sel_funct7;
    logic [36:0]       sel_instr;

    // A zero result means the combination is not decodable.
    function automatic logic [36:0] decode(input logic [6:0] opc, input logic [2:0] f3,
                                           input logic [6:0] f7);
        logic [36:0] onehot;
        logic        f7_zero;
        logic        f7_alt;
        onehot  = '0;
        f7_zero = (f7 == 7'b0000000);
        f7_alt  = (f7 == 7'b0100000);
        if (opc == 7'b0110011) begin
            case (f3)
                3'b000: begin onehot[0] = f7_zero; onehot[1] = f7_alt; end
                3'b100: onehot[2] = 1'b1;
                3'b110: onehot[3] = 1'b1;
                3'b111: onehot[4] = 1'b1;
                3'b001: onehot[5] = 1'b1;
                3'b101: begin onehot[6] = f7_zero; onehot[7] = f7_alt; end
                3'b010: onehot[8] = 1'b1;
                3'b011: onehot[9] = 1'b1;
                default: ;
            endcase
        end else if (opc == 7'b0010011) begin
            case (f3)
                3'b000: onehot[10] = 1'b1;
                3'b100: onehot[11] = 1'b1;
                3'b110: onehot[12] = 1'b1;
                3'b111: onehot[13] = 1'b1;
                3'b001: onehot[14] = f7_zero;
                3'b101: begin onehot[15] = f7_zero; onehot[16] = f7_alt; end
                3'b010: onehot[17] = 1'b1;
                3'b011: onehot[18] = 1'b1;
                default: ;
            endcase
        end
        return onehot;
    endfunction

    // On contention the requester that was not served last wins.
    assign grant      = (req0.valid && req1.valid) ? !last_grant_reg : req1.valid;
    assign accept     = (state_reg == IDLE) && (req0.valid || req1.valid);
    assign sel_opcode = grant ? req1.opcode : req0.opcode;
    assign sel_funct3 = grant ? req1.funct3 : req0.funct3;
    assign sel_funct7 = grant ? req1.funct7 : req0.funct7;
    assign sel_instr  = decode(sel_opcode, sel_funct3, sel_funct7);
    assign legal      = |sel_instr;
    assign last_issue = (cnt_reg == 4'(SETTLE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next       = state_reg;
        req0.ready       = 1'b0;
        req1.ready       = 1'b0;
        alu_instr        = '0;
        alu_rs1          = '0;
        alu_rs2          = '0;
        alu_imm          = '0;
        req0.rsp_valid   = 1'b0;
        req1.rsp_valid   = 1'b0;
        req0.rsp_illegal = 1'b0;
        req1.rsp_illegal = 1'b0;
        req0.rsp_data    = data_reg[0];
        req1.rsp_data    = data_reg[1];
        case (state_reg)
            IDLE: begin
                req0.ready = req0.valid && !grant;
                req1.ready = req1.valid && grant;
                if (accept) state_next = legal ? ISSUE : DONE;
            end
            ISSUE: begin
                alu_instr = instr_reg;
                alu_rs1   = rs1_reg;
                alu_rs2   = rs2_reg;
                alu_imm   = imm_reg;
                if (last_issue) state_next = DONE;
            end
            DONE: begin
                req0.rsp_valid   = !owner_reg;
                req1.rsp_valid   = owner_reg;
                req0.rsp_illegal = !owner_reg && illegal_reg;
                req1.rsp_illegal = owner_reg && illegal_reg;
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg        <= '0;
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
            illegal_reg    <= 1'b0;
            instr_reg      <= '0;
            rs1_reg        <= '0;
            rs2_reg        <= '0;
            imm_reg        <= '0;
        end else if (accept) begin
            cnt_reg        <= '0;
            last_grant_reg <= grant;
            owner_reg      <= grant;
            illegal_reg    <= !legal;
            instr_reg      <= sel_instr;
            rs1_reg        <= grant ? req1.rs1 : req0.rs1;
            rs2_reg        <= grant ? req1.rs2 : req0.rs2;
            imm_reg        <= grant ? req1.imm : req0.imm;
        end else if (state_reg == ISSUE) begin
            cnt_reg <= last_issue ? 4'd0 : cnt_reg + 4'd1;
        end
    end

    // Illegal operations clear the owner's result so DONE presents zero data.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        always_ff @(posedge clk) begin
            if (reset)
                data_reg[gi] <= '0;
            else if (accept && !legal && (grant == 1'(gi)))
                data_reg[gi] <= '0;
            else if ((state_reg == ISSUE) && last_issue && (owner_reg == 1'(gi)))
                data_reg[gi] <= alu_result;
        end
    end
endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: two instances (SETTLE_CYCLES 1 and 3), a timeline-based
// reference model checked every cycle, and directed operations with literal expectations.
module tb_alu_scheduler;
    localparam logic [6:0] R = 7'b0110011;
    localparam logic [6:0] I = 7'b0010011;
    localparam logic [6:0] ALT = 7'b0100000;
    localparam logic [6:0] Z = 7'b0000000;
    // {opcode, funct3, funct7, funct7 must match}; index = one-hot bit position
    localparam logic [17:0] DEC [19] = '{
        {R, 3'b000, Z, 1'b1}, {R, 3'b000, ALT, 1'b1}, {R, 3'b100, Z, 1'b0},
        {R, 3'b110, Z, 1'b0}, {R, 3'b111, Z, 1'b0}, {R, 3'b001, Z, 1'b0},
        {R, 3'b101, Z, 1'b1}, {R, 3'b101, ALT, 1'b1}, {R, 3'b010, Z, 1'b0},
        {R, 3'b011, Z, 1'b0}, {I, 3'b000, Z, 1'b0}, {I, 3'b100, Z, 1'b0},
        {I, 3'b110, Z, 1'b0}, {I, 3'b111, Z, 1'b0}, {I, 3'b001, Z, 1'b1},
        {I, 3'b101, Z, 1'b1}, {I, 3'b101, ALT, 1'b1}, {I, 3'b010, Z, 1'b0},
        {I, 3'b011, Z, 1'b0}};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_scheduler_if ri [4] ();
    logic [31:0] a_rs1 [2], a_rs2 [2], a_imm [2], a_res [2];
    logic [36:0] a_instr [2];

    logic        d_valid [4];
    logic [6:0]  d_opc [4], d_f7 [4];
    logic [2:0]  d_f3 [4];
    logic [31:0] d_rs1 [4], d_rs2 [4], d_imm [4];
    logic        o_ready [4], o_rv [4], o_ri [4];
    logic [31:0] o_rd [4];

    alu_scheduler #(.SETTLE_CYCLES(1)) dut_s1 (
        .clk(clk), .reset(reset), .req0(ri[0]), .req1(ri[1]),
        .alu_rs1(a_rs1[0]), .alu_rs2(a_rs2[0]), .alu_imm(a_imm[0]),
        .alu_instr(a_instr[0]), .alu_result(a_res[0]));
    alu_scheduler #(.SETTLE_CYCLES(3)) dut_s3 (
        .clk(clk), .reset(reset), .req0(ri[2]), .req1(ri[3]),
        .alu_rs1(a_rs1[1]), .alu_rs2(a_rs2[1]), .alu_imm(a_imm[1]),
        .alu_instr(a_instr[1]), .alu_result(a_res[1]));

    for (genvar gi = 0; gi < 4; gi++) begin : g_port
        assign ri[gi].valid  = d_valid[gi];
        assign ri[gi].opcode = d_opc[gi];
        assign ri[gi].funct3 = d_f3[gi];
        assign ri[gi].funct7 = d_f7[gi];
        assign ri[gi].rs1    = d_rs1[gi];
        assign ri[gi].rs2    = d_rs2[gi];
        assign ri[gi].imm    = d_imm[gi];
        assign o_ready[gi]   = ri[gi].ready;
        assign o_rv[gi]      = ri[gi].rsp_valid;
        assign o_ri[gi]      = ri[gi].rsp_illegal;
        assign o_rd[gi]      = ri[gi].rsp_data;
    end

    function automatic logic [31:0] ref_alu(input logic [36:0] ins, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] im);
        logic [31:0] r;
        case (1'b1)
            ins[0]:  r = a + b;
            ins[1]:  r = a - b;
            ins[2]:  r = a ^ b;
            ins[3]:  r = a | b;
            ins[4]:  r = a & b;
            ins[5]:  r = a << b[4:0];
            ins[6]:  r = a >> b[4:0];
            ins[7]:  r = $unsigned($signed(a) >>> b[4:0]);
            ins[8]:  r = {31'b0, $signed(a) < $signed(b)};
            ins[9]:  r = {31'b0, a < b};
            ins[10]: r = a + im;
            ins[11]: r = a ^ im;
            ins[12]: r = a | im;
            ins[13]: r = a & im;
            ins[14]: r = a << im[4:0];
            ins[15]: r = a >> im[4:0];
            ins[16]: r = $unsigned($signed(a) >>> im[4:0]);
            ins[17]: r = {31'b0, $signed(a) < $signed(im)};
            ins[18]: r = {31'b0, a < im};
            default: r = 32'hDEAD_BEEF;
        endcase
        return r;
    endfunction

    assign a_res[0] = ref_alu(a_instr[0], a_rs1[0], a_rs2[0], a_imm[0]);
    assign a_res[1] = ref_alu(a_instr[1], a_rs1[1], a_rs2[1], a_imm[1]);

    function automatic logic [36:0] model_decode(input logic [6:0] opc, input logic [2:0] f3,
                                                 input logic [6:0] f7);
        logic [36:0] m;
        m = '0;
        for (int e = 0; e < 19; e++)
            if (DEC[e][17:11] == opc && DEC[e][10:8] == f3 && (!DEC[e][0] || DEC[e][7:1] == f7))
                m[e] = 1'b1;
        return m;
    endfunction

    function automatic int settle(input int i);
        return (i == 1) ? 3 : 1;
    endfunction

    // Literal expectations posted by the stimulus, evaluated by the compare process.
    string       lit_name [512];
    logic [63:0] lit_act [512], lit_exp [512];
    int          lit_wr = 0;
    int          lit_rd = 0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    // Model: per instance, the accepted op and the cycle it was accepted on.
    bit          m_ok = 0;
    bit          m_busy [2], m_last [2], m_owner [2], m_ill [2];
    int          m_tacc [2];
    logic [36:0] m_instr [2];
    logic [31:0] m_rs1 [2], m_rs2 [2], m_imm [2], m_data [4];

    task automatic model_step(input int i);
        int k0, k, c, done_c, own;
        logic g, er0, er1, rv0, rv1, il0, il1;
        logic [1:0] v;
        logic [36:0] ei;
        logic [31:0] e1, e2, e3;
        logic [202:0] act, exp;
        k0 = 2 * i;
        v = {d_valid[k0 + 1], d_valid[k0]};
        c = cyc - m_tacc[i];
        done_c = m_ill[i] ? 1 : settle(i) + 1;
        own = m_owner[i] ? 1 : 0;
        {er0, er1, rv0, rv1, il0, il1} = '0;
        ei = '0; e1 = '0; e2 = '0; e3 = '0;
        g = (v == 2'b11) ? !m_last[i] : v[1];
        if (!m_busy[i]) begin
            er0 = v[0] && !g;
            er1 = v[1] && g;
        end else if (c == done_c) begin
            rv0 = (own == 0); rv1 = (own == 1);
            il0 = rv0 && m_ill[i]; il1 = rv1 && m_ill[i];
        end else begin
            ei = m_instr[i]; e1 = m_rs1[i]; e2 = m_rs2[i]; e3 = m_imm[i];
        end
        exp = {er1, er0, ei, e1, e2, e3, rv1, il1, m_data[k0 + 1], rv0, il0, m_data[k0]};
        act = {o_ready[k0 + 1], o_ready[k0], a_instr[i], a_rs1[i], a_rs2[i], a_imm[i],
               o_rv[k0 + 1], o_ri[k0 + 1], o_rd[k0 + 1], o_rv[k0], o_ri[k0], o_rd[k0]};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL cycle %0d inst %0d outputs actual=%h required=%h", cyc, i, act, exp);
        end
        if (!m_busy[i]) begin
            if (v != 2'b00) begin
                k = k0 + (g ? 1 : 0);
                m_busy[i]  = 1'b1;
                m_tacc[i]  = cyc;
                m_last[i]  = g;
                m_owner[i] = g;
                m_instr[i] = model_decode(d_opc[k], d_f3[k], d_f7[k]);
                m_ill[i]   = (m_instr[i] == '0);
                m_rs1[i]   = d_rs1[k];
                m_rs2[i]   = d_rs2[k];
                m_imm[i]   = d_imm[k];
                if (m_ill[i]) m_data[k] = '0;
            end
        end else if (c == done_c) begin
            m_busy[i] = 1'b0;
        end else if (c == settle(i)) begin
            m_data[k0 + own] = ref_alu(m_instr[i], m_rs1[i], m_rs2[i], m_imm[i]);
        end
    endtask

    always @(negedge clk) begin
        while (lit_rd < lit_wr) begin
            total++;
            if (lit_act[lit_rd] !== lit_exp[lit_rd]) begin
                bad++;
                $display("FAIL %s actual=%0h required=%0h", lit_name[lit_rd],
                         lit_act[lit_rd], lit_exp[lit_rd]);
            end
            lit_rd++;
        end
        if (m_ok) for (int i = 0; i < 2; i++) model_step(i);
        if (reset) begin
            m_ok = 1;
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 0; m_last[i] = 1; m_owner[i] = 0; m_ill[i] = 0; m_tacc[i] = 0;
            end
            for (int k = 0; k < 4; k++) m_data[k] = '0;
        end
        cyc++;
    end

    task automatic post(input string nm, input logic [63:0] act, input logic [63:0] exp);
        lit_name[lit_wr] = nm;
        lit_act[lit_wr]  = act;
        lit_exp[lit_wr]  = exp;
        lit_wr++;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic run_op(input int i, input int r, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic [36:0] e_instr,
                          input logic [31:0] e_data, input logic e_ill);
        int k, s;
        bit seen;
        k = 2 * i + r;
        s = settle(i);
        @(posedge clk); #1;
        d_valid[k] = 1'b1; d_opc[k] = opc; d_f3[k] = f3; d_f7[k] = f7;
        d_rs1[k] = rs1; d_rs2[k] = rs2; d_imm[k] = imm;
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = o_ready[k];
        end
        @(posedge clk); #1;
        d_valid[k] = 1'b0; d_rs1[k] = ~rs1; d_rs2[k] = rs2 ^ 32'h5A5A_5A5A; d_imm[k] = ~imm;
        d_opc[k] = 7'h33; d_f3[k] = ~f3; d_f7[k] = 7'h20;
        if (!seen) begin
            post("ready timeout", 64'd0, 64'd1);
            return;
        end
        seen = 0;
        for (int lat = 1; lat <= 12 && !seen; lat++) begin
            @(negedge clk);
            post("alu_instr", 64'(a_instr[i]), 64'((!e_ill && lat <= s) ? e_instr : 37'h0));
            if (o_rv[k]) begin
                seen = 1;
                post("rsp latency", 64'(lat), 64'(e_ill ? 1 : s + 1));
                post("rsp_data", 64'(o_rd[k]), 64'(e_data));
                post("rsp_illegal", 64'(o_ri[k]), 64'(e_ill));
            end
        end
        if (!seen) post("rsp timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int k0, nrsp;
        int order [4];
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d_valid[k] = 0; d_opc[k] = '0; d_f3[k] = '0; d_f7[k] = '0;
            d_rs1[k] = '0; d_rs2[k] = '0; d_imm[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            post("reset ready", 64'({o_ready[2*i+1], o_ready[2*i]}), 64'd0);
            post("reset alu_instr", 64'(a_instr[i]), 64'd0);
            post("reset rsp", 64'({o_rv[2*i+1], o_ri[2*i+1], o_rv[2*i], o_ri[2*i]}), 64'd0);
            post("reset rsp_data", {o_rd[2*i+1], o_rd[2*i]}, 64'd0);
        end
        @(posedge clk); #1 reset = 1'b0;

        for (int i = 0; i < 2; i++) begin
            k0 = 2 * i;
            run_op(i, 0, R, 3'b000, Z, 32'd5, 32'd7, 32'd0, 37'h1, 32'd12, 1'b0);
            run_op(i, 1, R, 3'b000, 7'b0000001, 32'd1, 32'd2, 32'd3, 37'h0, 32'd0, 1'b1);
            run_op(i, 0, I, 3'b101, ALT, 32'h8000_0000, 32'd0, 32'd4, 37'h10000, 32'hF800_0000, 1'b0);
            run_op(i, 1, R, 3'b011, Z, 32'd1, 32'hFFFF_FFFF, 32'd0, 37'h200, 32'd1, 1'b0);
            run_op(i, 0, I, 3'b000, Z, 32'd10, 32'd0, 32'hFFFF_FFFE, 37'h400, 32'd8, 1'b0);
            run_op(i, 1, R, 3'b000, ALT, 32'd3, 32'd5, 32'd0, 37'h2, 32'hFFFF_FFFE, 1'b0);
            run_op(i, 0, I, 3'b001, Z, 32'd1, 32'd0, 32'd31, 37'h4000, 32'h8000_0000, 1'b0);
            run_op(i, 0, 7'h7F, 3'b000, Z, 32'd9, 32'd9, 32'd9, 37'h0, 32'd0, 1'b1);

            // Round-robin under continuous contention straight after reset.
            pulse_reset();
            d_valid[k0] = 1; d_opc[k0] = R; d_f3[k0] = 3'b000; d_f7[k0] = Z;
            d_rs1[k0] = 32'd1; d_rs2[k0] = 32'd2;
            d_valid[k0+1] = 1; d_opc[k0+1] = R; d_f3[k0+1] = 3'b000; d_f7[k0+1] = ALT;
            d_rs1[k0+1] = 32'd10; d_rs2[k0+1] = 32'd3;
            nrsp = 0;
            for (int n = 0; n < 60 && nrsp < 4; n++) begin
                @(negedge clk);
                if (o_rv[k0]) begin
                    order[nrsp] = 0; nrsp++;
                    post("rr rsp0_data", 64'(o_rd[k0]), 64'd3);
                end else if (o_rv[k0+1]) begin
                    order[nrsp] = 1; nrsp++;
                    post("rr rsp1_data", 64'(o_rd[k0+1]), 64'd7);
                end
            end
            post("rr response count", 64'(nrsp), 64'd4);
            for (int j = 0; j < nrsp; j++) post("rr grant order", 64'(order[j]), 64'(j % 2));
            @(posedge clk); #1;
            d_valid[k0] = 0; d_valid[k0+1] = 0;
            repeat (10) @(posedge clk);
            #1;

            // Reset during ISSUE aborts the op; req0 then wins contention.
            d_valid[k0+1] = 1; d_opc[k0+1] = R; d_f3[k0+1] = 3'b000; d_f7[k0+1] = Z;
            d_rs1[k0+1] = 32'd20; d_rs2[k0+1] = 32'd22;
            @(negedge clk);
            post("abort setup ready1", 64'(o_ready[k0+1]), 64'd1);
            @(posedge clk); #1;
            d_valid[k0+1] = 0;
            reset = 1'b1;
            @(posedge clk); #1 reset = 1'b0;
            @(negedge clk);
            post("abort alu_instr", 64'(a_instr[i]), 64'd0);
            post("abort rsp_valid", 64'({o_rv[k0+1], o_rv[k0]}), 64'd0);
            @(posedge clk); #1;
            d_valid[k0] = 1; d_valid[k0+1] = 1;
            @(negedge clk);
            post("post-reset contention", 64'({o_ready[k0+1], o_ready[k0]}), 64'd1);
            @(posedge clk); #1;
            d_valid[k0] = 0; d_valid[k0+1] = 0;
            repeat (8) @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end
endmodule
